pio_arb: RTL and testbench

- Sequences and shares the ISP1362 16-bit PIO bus (CSF/RDF/WRF/ADDR/DATA) between two requesters: requester 0 = Host Controller agent, requester 1 = Device Controller agent.
- Generates strobe timing that meets the chip's access and recovery limits at 50 MHz.
- Arbitrates round-robin, with a lock that keeps a command+data sequence atomic.
- Sits between the HC/DC interface FSMs and the top-level tristate data pads.

---
 rtl/pio_arb.sv | 115 +++++++++++
 tb/tb_pio_arb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pio_arb.sv
// pio_arb: round-robin sharer and strobe sequencer for the ISP1362 16-bit PIO bus (req 0 = HC, req 1 = DC)
//   I_CLK, I_RST           : 50 MHz clock, async active-high reset
//   I_REQn/LOCKn/WRn/CMDn  : requester n access request, lock, write, command-port select
//   I_WDATAn               : requester n write data
//   O_GNTn, O_ACKn         : bus ownership, one-cycle completion pulse
//   O_RDATA                : last read data (shared)
//   O_PIO_*, I_PIO_DIN     : chip-side pins (ADDR = {owner, cmd}, CSF/RDF/WRF active low)
//   Optional macro PIO_LOCK_TMO_EN: release an idle lock after LOCK_TMO cycles.
module pio_arb #(
  parameter int STROBE_CYC  = 4,
  parameter int RECOVER_CYC = 10,
  parameter int LOCK_TMO    = 255
) (
  input  logic        I_CLK,
  input  logic        I_RST,
  input  logic        I_REQ0,
  input  logic        I_REQ1,
  input  logic        I_LOCK0,
  input  logic        I_LOCK1,
  input  logic        I_WR0,
  input  logic        I_WR1,
  input  logic        I_CMD0,
  input  logic        I_CMD1,
  input  logic [15:0] I_WDATA0,
  input  logic [15:0] I_WDATA1,
  output logic        O_GNT0,
  output logic        O_GNT1,
  output logic        O_ACK0,
  output logic        O_ACK1,
  output logic [15:0] O_RDATA,
  output logic [1:0]  O_PIO_ADDR,
  output logic        O_PIO_CSF,
  output logic        O_PIO_RDF,
  output logic        O_PIO_WRF,
  output logic [15:0] O_PIO_DOUT,
  output logic        O_PIO_DOE,
  input  logic [15:0] I_PIO_DIN
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;
  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic        r_last, r_lock, r_wr;
  logic [1:0]  r_addr;
  logic [15:0] r_wdata, r_rdata;
  logic        w_win, w_sel, w_owner_req, w_tmo, w_act, w_strobe, w_held;
  // r_addr[1] doubles as the current/last owner id
  assign w_owner_req = r_addr[1] ? I_REQ1 : I_REQ0;
  assign w_win = r_lock ? w_owner_req : (I_REQ0 | I_REQ1);
  assign w_sel = r_lock ? r_addr[1] : (I_REQ0 & I_REQ1) ? ~r_last : I_REQ1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_win ? SETUP : IDLE;
      SETUP:   w_next = STROBE;
      STROBE:  w_next = (r_cnt == 6'd0) ? HOLD : STROBE;
      HOLD:    w_next = RECOVER;
      RECOVER: w_next = (r_cnt == 6'd0) ? IDLE : RECOVER;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_lock  <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == SETUP) ? 6'(STROBE_CYC - 1) :
                 (r_state == HOLD)  ? 6'(RECOVER_CYC - 1) : r_cnt - 6'(r_cnt != 6'd0);
      if (r_state == IDLE && w_win) begin
        r_last  <= w_sel;
        r_addr  <= {w_sel, w_sel ? I_CMD1 : I_CMD0};
        r_wr    <= w_sel ? I_WR1 : I_WR0;
        r_wdata <= w_sel ? I_WDATA1 : I_WDATA0;
      end
      if (r_state == STROBE && r_cnt == 6'd0 && !r_wr) r_rdata <= I_PIO_DIN;
      if (r_state == HOLD) r_lock <= r_addr[1] ? I_LOCK1 : I_LOCK0;
      else if (w_tmo) r_lock <= 1'b0;
    end
  end
`ifdef PIO_LOCK_TMO_EN
  localparam int TW = $clog2(LOCK_TMO + 1);
  logic [TW-1:0] r_tmo;
  logic          w_idle_lock;
  // counts idle cycles a lock is held without the owner asking for the bus
  assign w_idle_lock = r_state == IDLE && r_lock && !w_owner_req;
  assign w_tmo = w_idle_lock && r_tmo == TW'(LOCK_TMO - 1);
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) r_tmo <= '0;
    else r_tmo <= (w_idle_lock && !w_tmo) ? r_tmo + 1'b1 : '0;
  end
`else
  // LOCK_TMO is always positive, so this is a constant 0
  assign w_tmo = LOCK_TMO < 0;
`endif
  assign w_act      = r_state == SETUP || r_state == STROBE || r_state == HOLD;
  assign w_strobe   = r_state == STROBE;
  assign w_held     = r_state != IDLE || r_lock;
  assign O_GNT0     = w_held & ~r_addr[1];
  assign O_GNT1     = w_held & r_addr[1];
  assign O_ACK0     = r_state == HOLD && !r_addr[1];
  assign O_ACK1     = r_state == HOLD && r_addr[1];
  assign O_RDATA    = r_rdata;
  assign O_PIO_ADDR = r_addr;
  assign O_PIO_CSF  = ~w_act;
  assign O_PIO_RDF  = ~(w_strobe & ~r_wr);
  assign O_PIO_WRF  = ~(w_strobe & r_wr);
  assign O_PIO_DOUT = r_wdata;
  assign O_PIO_DOE  = w_act & r_wr;
endmodule

// File: tb/tb_pio_arb.sv
// tb_pio_arb: directed + random checks of pio_arb against a phase-count reference model
module tb_pio_arb;
  localparam int S = 4, R = 10, LT = 255;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, wr0 = 0, wr1 = 0, cmd0 = 0, cmd1 = 0;
  logic [15:0] wdata0 = 0, wdata1 = 0, din = 0;
  logic gnt0, gnt1, ack0, ack1, csf, rdf, wrf, doe;
  logic [15:0] rdata, dout;
  logic [1:0] addr;
  int n_vec = 0, n_err = 0;
  pio_arb dut (
    .I_CLK(clk), .I_RST(rst), .I_REQ0(req0), .I_REQ1(req1), .I_LOCK0(lock0), .I_LOCK1(lock1),
    .I_WR0(wr0), .I_WR1(wr1), .I_CMD0(cmd0), .I_CMD1(cmd1), .I_WDATA0(wdata0), .I_WDATA1(wdata1),
    .O_GNT0(gnt0), .O_GNT1(gnt1), .O_ACK0(ack0), .O_ACK1(ack1), .O_RDATA(rdata),
    .O_PIO_ADDR(addr), .O_PIO_CSF(csf), .O_PIO_RDF(rdf), .O_PIO_WRF(wrf),
    .O_PIO_DOUT(dout), .O_PIO_DOE(doe), .I_PIO_DIN(din)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: p = cycles elapsed since the grant edge (0 = idle)
  int p, m_tmo;
  bit m_own, m_last, m_wr, m_cmd, m_lock;
  logic [15:0] m_wd, m_rd;
  initial forever begin
    bit rq[2], lk[2], win, w;
    @(posedge clk);
    rq[0] = req0; rq[1] = req1; lk[0] = lock0; lk[1] = lock1;
    if (rst) begin
      p = 0; m_tmo = 0; m_own = 0; m_last = 1; m_wr = 0; m_cmd = 0; m_lock = 0; m_wd = 0; m_rd = 0;
    end else if (p == 0) begin
      win = m_lock ? rq[m_own] : (req0 | req1);
      w = m_lock ? m_own : (req0 && req1) ? !m_last : req1;
`ifdef PIO_LOCK_TMO_EN
      if (m_lock && !rq[m_own]) begin
        m_tmo++;
        if (m_tmo == LT) begin m_lock = 0; m_tmo = 0; end
      end else m_tmo = 0;
`endif
      if (win) begin
        p = 1; m_own = w; m_last = w;
        m_wr = w ? wr1 : wr0; m_cmd = w ? cmd1 : cmd0; m_wd = w ? wdata1 : wdata0;
      end
    end else if (p == S + R + 2) p = 0;
    else begin
      if (p == S + 1 && !m_wr) m_rd = din;
      if (p == S + 2) m_lock = lk[m_own];
      p++;
    end
    #1;
    begin
      bit act, stb, held;
      act = p >= 1 && p <= S + 2; stb = p >= 2 && p <= S + 1; held = p != 0 || m_lock;
      chk("gnt", {gnt1, gnt0}, {held && m_own, held && !m_own});
      chk("ack", {ack1, ack0}, {p == S + 2 && m_own, p == S + 2 && !m_own});
      chk("pins", {csf, rdf, wrf, doe}, {!act, !(stb && !m_wr), !(stb && m_wr), act && m_wr});
      chk("addr", addr, {m_own, m_cmd});
      chk("dout", dout, m_wd);
      chk("rdata", rdata, m_rd);
      chk("doe_vs_rdf", doe & ~rdf, 0);
    end
  end
  task automatic wait_any(output int n, output bit who);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(ack0 | ack1) && n < 400);
    chk("ack_seen", ack0 | ack1, 1);
    who = ack1;
  endtask
  initial begin
    int n;
    bit who;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pins", {csf, rdf, wrf, doe}, 4'b1110);
    chk("rst_gnt_ack", {gnt1, gnt0, ack1, ack0}, 0);
    chk("rst_rdata_addr", rdata | dout | addr, 0);
    @(negedge clk) rst = 0;
    // 1: single read
    @(negedge clk) begin req0 = 1; wr0 = 0; cmd0 = 1; din = 16'h3630; end
    wait_any(n, who);
    chk("t1_lat", 16'(n), 6); chk("t1_who", who, 0);
    chk("t1_addr", addr, 2'b01); chk("t1_rdata", rdata, 16'h3630);
    @(negedge clk) req0 = 0;
    repeat (R + 1) @(posedge clk);
    // 2: single write
    @(negedge clk) begin req1 = 1; wr1 = 1; cmd1 = 0; wdata1 = 16'hA5C3; din = 16'h1234; end
    wait_any(n, who);
    chk("t2_lat", 16'(n), 6); chk("t2_who", who, 1);
    chk("t2_addr", addr, 2'b10); chk("t2_dout", dout, 16'hA5C3);
    chk("t2_doe", doe, 1); chk("t2_rdata", rdata, 16'h3630);
    @(negedge clk) begin req1 = 0; wr1 = 0; end
    repeat (R + 1) @(posedge clk);
    // 3: contention alternates and runs at the back-to-back period
    @(negedge clk) begin req0 = 1; req1 = 1; end
    for (int k = 0; k < 4; k++) begin
      wait_any(n, who);
      chk("t3_order", who, 16'(k % 2));
      if (k > 0) chk("t3_period", 16'(n), 16'(S + R + 3));
    end
    @(negedge clk) begin req0 = 0; req1 = 0; end
    repeat (R + 1) @(posedge clk);
    // 4: lock keeps requester 0 on the bus for two accesses
    @(negedge clk) begin req0 = 1; lock0 = 1; wr0 = 1; cmd0 = 1; wdata0 = 16'h00B5; req1 = 1; end
    wait_any(n, who); chk("t4_first", who, 0);
    @(posedge clk);
    @(negedge clk) begin lock0 = 0; wr0 = 0; cmd0 = 0; end
    wait_any(n, who); chk("t4_second", who, 0);
    @(negedge clk) req0 = 0;
    wait_any(n, who); chk("t4_third", who, 1);
    @(negedge clk) req1 = 0;
    repeat (R + 1) @(posedge clk);
    // 5: reset in STROBE cycle 2
    @(negedge clk) begin req0 = 1; wr0 = 0; end
    repeat (3) @(posedge clk);
    #1 chk("t5_in_strobe", rdf, 0);
    #2 rst = 1;
    #1;
    chk("t5_pins", {csf, rdf, wrf, doe}, 4'b1110);
    chk("t5_ack_gnt", {ack1, ack0, gnt1, gnt0}, 0);
    @(posedge clk);
    @(negedge clk) begin rst = 0; req1 = 1; end
    wait_any(n, who); chk("t5_tie", who, 0);
    @(negedge clk) begin req0 = 0; req1 = 0; end
    repeat (R + 1) @(posedge clk);
    // 6: lock held with the owner idle
    @(negedge clk) begin req0 = 1; lock0 = 1; wr0 = 0; end
    @(negedge clk) req1 = 1;
    wait_any(n, who); chk("t6_owner", who, 0);
    @(posedge clk);
    @(negedge clk) begin req0 = 0; lock0 = 0; end
    n = 1;
    while (!gnt1 && n < 400) begin @(posedge clk); #1; n++; end
`ifdef PIO_LOCK_TMO_EN
    chk("t6_tmo", 16'(n), 16'(S + R + 3 + LT + 1 - S - R - 3 + 11));
    wait_any(n, who); chk("t6_after", who, 1);
`else
    chk("t6_gnt1", gnt1, 0); chk("t6_gnt0", gnt0, 1);
    @(negedge clk) req0 = 1;
    wait_any(n, who); chk("t6_release", who, 0);
    @(negedge clk) req0 = 0;
    wait_any(n, who); chk("t6_after", who, 1);
`endif
    @(negedge clk) req1 = 0;
    repeat (R + 1) @(posedge clk);
    // random traffic, fields and lock wiggle every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (ack0) req0 = 1'($urandom_range(1)); else if (!req0) req0 = $urandom_range(3) == 0;
      if (ack1) req1 = 1'($urandom_range(1)); else if (!req1) req1 = $urandom_range(3) == 0;
      lock0 = $urandom_range(3) == 0; lock1 = $urandom_range(3) == 0;
      wr0 = 1'($urandom); wr1 = 1'($urandom); cmd0 = 1'($urandom); cmd1 = 1'($urandom);
      wdata0 = 16'($urandom); wdata1 = 16'($urandom); din = 16'($urandom);
    end
    @(negedge clk) begin req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; end
    repeat (40) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
